pm_sched: RTL and testbench

- Two-requester scheduler that shares the processor datapath between independent command sources.
- Accepts one command at a time under round-robin arbitration.
- Sequences the datapath control lines (register write enables w, ALU/function code ce, operand mux select sel) through setup, execute and writeback.
- Returns the datapath status flags s to the winning requester with a done pulse.

---
 rtl/pm_sched_if.sv | 30 +++
 rtl/pm_sched.sv | 106 ++++++++++
 tb/tb_pm_sched.sv | 429 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pm_sched_if.sv
// Command/status bundle between the two requesters, the datapath and pm_sched.
// The master side drives requests, enable and datapath status; the slave side is the scheduler.
interface pm_sched_if;
    logic       en;
    logic       req0;
    logic [8:0] cmd0;
    logic       req1;
    logic [8:0] cmd1;
    logic [2:0] s;
    logic       gnt0;
    logic       gnt1;
    logic       busy;
    logic [2:0] w;
    logic [3:0] ce;
    logic [1:0] sel;
    logic       done;
    logic       done_id;
    logic [2:0] status;
    logic [2:0] cs;

    modport master (
        output en, req0, cmd0, req1, cmd1, s,
        input  gnt0, gnt1, busy, w, ce, sel, done, done_id, status, cs
    );

    modport slave (
        input  en, req0, cmd0, req1, cmd1, s,
        output gnt0, gnt1, busy, w, ce, sel, done, done_id, status, cs
    );
endinterface

// File: rtl/pm_sched.sv
// Round-robin scheduler sharing one datapath between two command sources;
// sequences setup, execute and writeback and returns captured status with a done pulse.
module pm_sched #(
    parameter int unsigned EXEC_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    pm_sched_if.slave   bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        EXEC  = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(EXEC_CYCLES - 1);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [8:0] cmd_q, cmd_d;
    logic       id_q, id_d;
    logic       rr_q, rr_d;
    logic [2:0] status_q, status_d;
    logic       win;
    logic       active;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            cmd_q    <= '0;
            id_q     <= 1'b0;
            rr_q     <= 1'b0;
            status_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            cmd_q    <= cmd_d;
            id_q     <= id_d;
            rr_q     <= rr_d;
            status_q <= status_d;
        end
    end

    // rr only breaks ties; a lone requester always wins
    assign win = (bus.req0 && bus.req1) ? rr_q : bus.req1;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        cmd_d    = cmd_q;
        id_d     = id_q;
        rr_d     = rr_q;
        status_d = status_q;
        if (bus.en) begin
            case (state_q)
                IDLE: begin
                    if (bus.req0 || bus.req1) begin
                        id_d    = win;
                        cmd_d   = win ? bus.cmd1 : bus.cmd0;
                        rr_d    = ~win;
                        state_d = SETUP;
                    end
                end
                SETUP: begin
                    cnt_d   = CNT_LOAD;
                    state_d = EXEC;
                end
                EXEC: begin
                    if (cnt_q == 4'd0) begin
                        state_d = WRITE;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
                WRITE: begin
                    status_d = bus.s;
                    state_d  = DONE;
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Pulsed outputs are gated by en so a frozen cycle replays its action exactly once
    assign active      = (state_q == SETUP) || (state_q == EXEC) || (state_q == WRITE);
    assign bus.ce      = active ? cmd_q[8:5] : 4'd0;
    assign bus.sel     = active ? cmd_q[4:3] : 2'd0;
    assign bus.w       = (bus.en && state_q == WRITE) ? cmd_q[2:0] : 3'd0;
    assign bus.gnt0    = bus.en && (state_q == SETUP) && !id_q;
    assign bus.gnt1    = bus.en && (state_q == SETUP) && id_q;
    assign bus.done    = bus.en && (state_q == DONE);
    assign bus.done_id = bus.done && id_q;
    assign bus.busy    = (state_q != IDLE);
    assign bus.status  = status_q;
    assign bus.cs      = state_q;

endmodule

// File: tb/tb_pm_sched.sv
// Bench for pm_sched: directed scenarios against fixed timelines plus random traffic
// compared against a phase-counting transaction model.
module tb_pm_sched;

    localparam int EX = 2;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    pm_sched_if bus ();

    pm_sched #(.EXEC_CYCLES(EX)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: a job walks through phases 1..EX+3 counted in enabled cycles after acceptance
    logic       m_active;
    int         m_k;
    logic [8:0] m_cmd;
    logic       m_id;
    logic       m_rr;
    logic [2:0] m_status;
    wire        m_pick = (bus.req0 && bus.req1) ? m_rr : bus.req1;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_active <= 1'b0;
            m_k      <= 0;
            m_cmd    <= '0;
            m_id     <= 1'b0;
            m_rr     <= 1'b0;
            m_status <= '0;
        end else if (bus.en) begin
            if (!m_active) begin
                if (bus.req0 || bus.req1) begin
                    m_active <= 1'b1;
                    m_k      <= 1;
                    m_id     <= m_pick;
                    m_cmd    <= m_pick ? bus.cmd1 : bus.cmd0;
                    m_rr     <= ~m_pick;
                end
            end else begin
                if (m_k == EX + 2) m_status <= bus.s;
                if (m_k == EX + 3) m_active <= 1'b0;
                else m_k <= m_k + 1;
            end
        end
    end

    function automatic logic [19:0] model_vec();
        logic       g0, g1, dn, di, run;
        logic [2:0] w_e, cs_e;
        logic [3:0] ce_e;
        logic [1:0] sel_e;
        run   = m_active && (m_k <= EX + 2);
        g0    = bus.en && m_active && (m_k == 1) && !m_id;
        g1    = bus.en && m_active && (m_k == 1) && m_id;
        dn    = bus.en && m_active && (m_k == EX + 3);
        di    = dn && m_id;
        w_e   = (bus.en && m_active && m_k == EX + 2) ? m_cmd[2:0] : 3'd0;
        ce_e  = run ? m_cmd[8:5] : 4'd0;
        sel_e = run ? m_cmd[4:3] : 2'd0;
        if (!m_active)            cs_e = 3'd0;
        else if (m_k == 1)        cs_e = 3'd1;
        else if (m_k <= EX + 1)   cs_e = 3'd2;
        else if (m_k == EX + 2)   cs_e = 3'd3;
        else                      cs_e = 3'd4;
        return {g0, g1, m_active, w_e, ce_e, sel_e, dn, di, m_status, cs_e};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset    = 1'b0;
        bus.en   = 1'b1;
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        bus.cmd0 = '0;
        bus.cmd1 = '0;
        bus.s    = '0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset    = 1'b0;
        bus.en   = 1'b1;
        bus.req0 = 1'b1;
        bus.req1 = 1'b0;
        bus.cmd0 = {4'h7, 2'b11, 3'b101};
        bus.cmd1 = '0;
        bus.s    = 3'b111;
        tick();
        @(negedge clk);
        n_checks++;
        if ({bus.cs, bus.busy, bus.w, bus.ce, bus.sel, bus.gnt0, bus.done, bus.status} !== '0) begin
            n_errors++;
            $display("FAIL reset_hold got cs=%0d busy=%b w=%b ce=%h sel=%b gnt0=%b done=%b status=%b want all 0",
                     bus.cs, bus.busy, bus.w, bus.ce, bus.sel, bus.gnt0, bus.done, bus.status);
        end
        tick();
        reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (c == 2) begin
                n_checks++;
                if (bus.ce !== 4'h7 || bus.cs !== 3'd2) begin
                    n_errors++;
                    $display("FAIL reset_pre_exec got ce=%h cs=%0d want ce=7 cs=2", bus.ce, bus.cs);
                end
            end else begin
                tick();
            end
        end
        #2;
        reset = 1'b0;
        #1;
        n_checks++;
        if (bus.cs !== 3'd0 || bus.w !== 3'd0 || bus.ce !== 4'd0 || bus.sel !== 2'd0 ||
            bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.status !== 3'd0) begin
            n_errors++;
            $display("FAIL reset_async got cs=%0d w=%b ce=%h sel=%b busy=%b done=%b status=%b want all 0",
                     bus.cs, bus.w, bus.ce, bus.sel, bus.busy, bus.done, bus.status);
        end
        bus.req0 = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    task automatic test_single();
        logic       eg;
        logic       ed;
        logic       eb;
        logic [3:0] ece;
        logic [1:0] esel;
        logic [2:0] ew;
        logic [2:0] est;
        do_reset();
        bus.req0 = 1'b1;
        bus.cmd0 = {4'h3, 2'b10, 3'b001};
        bus.s    = 3'b010;
        for (int c = 0; c <= 6; c++) begin
            @(negedge clk);
            eg   = (c == 1);
            ed   = (c == 5);
            eb   = (c >= 1 && c <= 5);
            ece  = (c >= 1 && c <= 4) ? 4'h3 : 4'h0;
            esel = (c >= 1 && c <= 4) ? 2'b10 : 2'b00;
            ew   = (c == 4) ? 3'b001 : 3'b000;
            est  = (c >= 5) ? 3'b101 : 3'b000;
            n_checks++;
            if (bus.gnt0 !== eg || bus.gnt1 !== 1'b0) begin
                n_errors++;
                $display("FAIL single_gnt c=%0d got gnt0=%b gnt1=%b want gnt0=%b gnt1=0", c, bus.gnt0, bus.gnt1, eg);
            end
            n_checks++;
            if (bus.ce !== ece || bus.sel !== esel) begin
                n_errors++;
                $display("FAIL single_ce_sel c=%0d got ce=%h sel=%b want ce=%h sel=%b", c, bus.ce, bus.sel, ece, esel);
            end
            n_checks++;
            if (bus.w !== ew) begin
                n_errors++;
                $display("FAIL single_w c=%0d got %b want %b", c, bus.w, ew);
            end
            n_checks++;
            if (bus.done !== ed || bus.done_id !== 1'b0 || bus.busy !== eb) begin
                n_errors++;
                $display("FAIL single_done c=%0d got done=%b id=%b busy=%b want done=%b id=0 busy=%b",
                         c, bus.done, bus.done_id, bus.busy, ed, eb);
            end
            n_checks++;
            if (bus.status !== est) begin
                n_errors++;
                $display("FAIL single_status c=%0d got %b want %b", c, bus.status, est);
            end
            tick();
            if (c + 1 == 2) begin
                bus.req0 = 1'b0;
                bus.cmd0 = 9'h1FF;
            end
            bus.s = (c + 1 == 4) ? 3'b101 : 3'b010;
        end
    endtask

    task automatic test_contention();
        int g_id[$];
        int g_cyc[$];
        int d_id[$];
        do_reset();
        bus.req0 = 1'b1;
        bus.req1 = 1'b1;
        bus.cmd0 = 9'h0A1;
        bus.cmd1 = 9'h152;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            n_checks++;
            if ((bus.gnt0 && bus.gnt1) || (bus.done && (bus.gnt0 || bus.gnt1))) begin
                n_errors++;
                $display("FAIL cont_overlap c=%0d got gnt0=%b gnt1=%b done=%b want at most one high",
                         c, bus.gnt0, bus.gnt1, bus.done);
            end
            if (bus.gnt0 || bus.gnt1) begin
                g_id.push_back(bus.gnt1 ? 1 : 0);
                g_cyc.push_back(c);
            end
            if (bus.done) d_id.push_back(int'(bus.done_id));
            tick();
        end
        n_checks++;
        if (g_id.size() != 4) begin
            n_errors++;
            $display("FAIL cont_count got %0d grants want 4", g_id.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (g_id[i] != (i % 2) || g_cyc[i] != 1 + 6 * i) begin
                    n_errors++;
                    $display("FAIL cont_order i=%0d got id=%0d cycle=%0d want id=%0d cycle=%0d",
                             i, g_id[i], g_cyc[i], i % 2, 1 + 6 * i);
                end
            end
        end
        n_checks++;
        if (d_id.size() < 3 || d_id[0] != 0 || d_id[1] != 1 || d_id[2] != 0) begin
            n_errors++;
            $display("FAIL cont_done_id got %0d dones want ids 0,1,0 in order", d_id.size());
        end
    endtask

    task automatic test_stall_exec();
        int w_cnt;
        int w_cyc;
        int d_cyc;
        do_reset();
        w_cnt = 0;
        w_cyc = -1;
        d_cyc = -1;
        bus.req1 = 1'b1;
        bus.cmd1 = {4'h9, 2'b01, 3'b110};
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (c == 1) begin
                n_checks++;
                if (bus.gnt1 !== 1'b1) begin
                    n_errors++;
                    $display("FAIL stall_exec_gnt got gnt1=%b want 1", bus.gnt1);
                end
            end
            if (!bus.en) begin
                n_checks++;
                if (bus.w !== 3'd0 || bus.ce !== 4'h9) begin
                    n_errors++;
                    $display("FAIL stall_exec_frozen c=%0d got w=%b ce=%h want w=000 ce=9", c, bus.w, bus.ce);
                end
            end
            if (bus.w !== 3'd0) begin
                w_cnt++;
                w_cyc = c;
            end
            if (bus.done === 1'b1 && d_cyc < 0) d_cyc = c;
            tick();
            if (c + 1 == 2) bus.req1 = 1'b0;
            bus.en = !(c + 1 >= 2 && c + 1 <= 4);
        end
        n_checks++;
        if (w_cnt != 1 || w_cyc != 7) begin
            n_errors++;
            $display("FAIL stall_exec_w got pulses=%0d at cycle %0d want 1 at cycle 7", w_cnt, w_cyc);
        end
        n_checks++;
        if (d_cyc != 8) begin
            n_errors++;
            $display("FAIL stall_exec_done got cycle %0d want 8", d_cyc);
        end
    endtask

    task automatic test_stall_write();
        logic [2:0] ew;
        do_reset();
        bus.req0 = 1'b1;
        bus.cmd0 = {4'h5, 2'b11, 3'b011};
        bus.s    = 3'b001;
        for (int c = 0; c <= 8; c++) begin
            @(negedge clk);
            if (c >= 4 && c <= 7) begin
                ew = (c == 6) ? 3'b011 : 3'b000;
                n_checks++;
                if (bus.w !== ew) begin
                    n_errors++;
                    $display("FAIL stall_write_w c=%0d got %b want %b", c, bus.w, ew);
                end
                n_checks++;
                if (bus.done !== (c == 7)) begin
                    n_errors++;
                    $display("FAIL stall_write_done c=%0d got %b want %b", c, bus.done, (c == 7));
                end
            end
            if (c == 7) begin
                n_checks++;
                if (bus.status !== 3'b010 || bus.done_id !== 1'b0) begin
                    n_errors++;
                    $display("FAIL stall_write_status got status=%b id=%b want 010 id=0", bus.status, bus.done_id);
                end
            end
            tick();
            if (c + 1 == 2) bus.req0 = 1'b0;
            bus.en = !(c + 1 == 4 || c + 1 == 5);
            bus.s  = (c + 1 == 4 || c + 1 == 5) ? 3'b111 : (c + 1 == 6) ? 3'b010 : 3'b001;
        end
    endtask

    task automatic test_abort();
        do_reset();
        bus.req0 = 1'b1;
        bus.cmd0 = {4'hA, 2'b01, 3'b111};
        bus.cmd1 = {4'h2, 2'b10, 3'b100};
        bus.s    = 3'b110;
        for (int c = 0; c < 10; c++) tick();
        @(negedge clk);
        n_checks++;
        if (bus.w !== 3'b111 || bus.status !== 3'b110) begin
            n_errors++;
            $display("FAIL abort_pre got w=%b status=%b want w=111 status=110", bus.w, bus.status);
        end
        #2;
        reset    = 1'b0;
        bus.req0 = 1'b0;
        bus.req1 = 1'b1;
        #1;
        n_checks++;
        if (bus.w !== 3'd0 || bus.cs !== 3'd0 || bus.busy !== 1'b0 || bus.ce !== 4'd0 || bus.status !== 3'd0) begin
            n_errors++;
            $display("FAIL abort_async got w=%b cs=%0d busy=%b ce=%h status=%b want all 0",
                     bus.w, bus.cs, bus.busy, bus.ce, bus.status);
        end
        tick();
        @(negedge clk);
        n_checks++;
        if (bus.done !== 1'b0 || bus.w !== 3'd0) begin
            n_errors++;
            $display("FAIL abort_no_done got done=%b w=%b want 0", bus.done, bus.w);
        end
        tick();
        reset = 1'b1;
        for (int c = 0; c <= 6; c++) begin
            @(negedge clk);
            n_checks++;
            if (bus.gnt1 !== (c == 1) || bus.gnt0 !== 1'b0) begin
                n_errors++;
                $display("FAIL abort_regrant c=%0d got gnt0=%b gnt1=%b want gnt0=0 gnt1=%b",
                         c, bus.gnt0, bus.gnt1, (c == 1));
            end
            if (c == 5) begin
                n_checks++;
                if (bus.done !== 1'b1 || bus.done_id !== 1'b1) begin
                    n_errors++;
                    $display("FAIL abort_done got done=%b id=%b want 1 1", bus.done, bus.done_id);
                end
            end
            tick();
            if (c + 1 == 2) bus.req1 = 1'b0;
        end
    endtask

    task automatic test_random();
        logic [19:0] got;
        logic [19:0] exp;
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            bus.en   = ($urandom_range(0, 7) != 0);
            bus.req0 = ($urandom_range(0, 2) == 0);
            bus.req1 = ($urandom_range(0, 2) == 0);
            bus.cmd0 = 9'($urandom);
            bus.cmd1 = 9'($urandom);
            bus.s    = 3'($urandom);
            reset    = ($urandom_range(0, 199) != 0);
            @(negedge clk);
            got = {bus.gnt0, bus.gnt1, bus.busy, bus.w, bus.ce, bus.sel,
                   bus.done, bus.done_id, bus.status, bus.cs};
            exp = model_vec();
            n_checks++;
            if (got !== exp) begin
                n_errors++;
                $display("FAIL random c=%0d got %h want %h", c, got, exp);
            end
            n_checks++;
            if ((bus.gnt0 && bus.gnt1) || (bus.done && (bus.gnt0 || bus.gnt1))) begin
                n_errors++;
                $display("FAIL random_excl c=%0d got gnt0=%b gnt1=%b done=%b want at most one",
                         c, bus.gnt0, bus.gnt1, bus.done);
            end
            tick();
        end
        reset = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1);
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        test_reset();
        test_single();
        test_contention();
        test_stall_exec();
        test_stall_write();
        test_abort();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
